// File: rtl/rib_arbiter_pkg.sv
// Shared RIB bus definitions: default widths, slave-select field and master/slave IDs.
package rib_arbiter_pkg;

  localparam int unsigned RIB_ADDR_W = 32;
  localparam int unsigned RIB_DATA_W = 32;
  // Slave index lives in the top nibble of the address, addr[31:28]
  localparam int unsigned RIB_SEL_W  = 4;

  typedef enum logic [3:0] {
    RIB_S_ROM   = 4'd0,
    RIB_S_RAM   = 4'd1,
    RIB_S_UART  = 4'd2,
    RIB_S_TIMER = 4'd3
  } rib_slave_e;

  typedef enum logic [1:0] {
    RIB_M_LOADER  = 2'd0,
    RIB_M_CORE_WR = 2'd1,
    RIB_M_CORE_RD = 2'd2
  } rib_master_e;

endpackage

// File: rtl/rib_arbiter_prio_pick.sv
// Lowest-index one-hot picker over a request vector, skipping masked entries.
module rib_arbiter_prio_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] excl_i,
  output logic [N-1:0] pick_o,
  output logic         any_o
);

  logic found;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !excl_i[i] && !found) begin
        pick_o[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter/decoder: registered owner grant, combinational slave mux, 1-cycle read return.
// Build macro RIB_TIMEOUT_EN adds an ownership watchdog that drives err_o.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int unsigned       NUM_M       = 3,
  parameter int unsigned       NUM_S       = 4,
  parameter int unsigned       ADDR_W      = RIB_ADDR_W,
  parameter int unsigned       DATA_W      = RIB_DATA_W,
  parameter int unsigned       PARK_M      = RIB_M_CORE_RD,
  parameter logic [NUM_M-1:0]  CORE_MASK   = 3'b110,
  parameter int unsigned       STARVE_MAX  = 8,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_req_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_M*DATA_W-1:0] m_wdata_i,
  output logic [NUM_M-1:0]        m_gnt_o,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic [NUM_M-1:0]        m_rvalid_o,
  output logic [NUM_S-1:0]        s_sel_o,
  output logic                    s_we_o,
  output logic [ADDR_W-1:0]       s_addr_o,
  output logic [DATA_W-1:0]       s_wdata_o,
  input  logic [NUM_S*DATA_W-1:0] s_rdata_i,
  output logic                    core_hold_o,
  output logic                    err_o
);

  localparam int unsigned      MW      = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned      SC_W    = $clog2(STARVE_MAX + 1);
  localparam logic [NUM_M-1:0] PARK_OH = NUM_M'(1) << PARK_M;

  logic [NUM_M-1:0]     gnt_q, gnt_d, pick_oh;
  logic [MW-1:0]        owner_q, owner_d;
  logic [SC_W-1:0]      starve_q, starve_d;
  logic                 pick_any, own_req, own_we, own_rd, keep, others_req, to_hit;
  logic [ADDR_W-1:0]    own_addr;
  logic [RIB_SEL_W-1:0] own_sidx;
  logic                 rsp_v_q;
  logic [MW-1:0]        rsp_m_q;
  logic [RIB_SEL_W-1:0] rsp_s_q;
  logic [DATA_W-1:0]    rdata_q, rd_mux;

  assign own_req  = m_req_i[owner_q];
  assign own_we   = m_we_i[owner_q];
  assign own_rd   = own_req && !own_we;
  assign own_addr = m_addr_i[int'(owner_q)*ADDR_W +: ADDR_W];
  assign own_sidx = own_addr[ADDR_W-1 -: RIB_SEL_W];

  assign s_we_o    = own_req && own_we;
  assign s_addr_o  = own_addr;
  assign s_wdata_o = m_wdata_i[int'(owner_q)*DATA_W +: DATA_W];

  // Indices at or above NUM_S match no bit, so unmapped accesses select nothing
  always_comb begin
    s_sel_o = '0;
    for (int unsigned s = 0; s < NUM_S; s++)
      s_sel_o[s] = own_req && (32'(own_sidx) == s);
  end

  assign m_gnt_o     = gnt_q;
  assign core_hold_o = |(m_req_i & ~gnt_q & CORE_MASK);

  rib_arbiter_prio_pick #(.N(NUM_M)) u_pick (
    .req_i  (m_req_i),
    .excl_i (gnt_q),
    .pick_o (pick_oh),
    .any_o  (pick_any)
  );

  assign others_req = |(m_req_i & ~gnt_q);
  assign keep       = own_req && (starve_q < SC_W'(STARVE_MAX)) && !to_hit;
  assign gnt_d      = keep ? gnt_q : (pick_any ? pick_oh : PARK_OH);

  always_comb begin
    owner_d = '0;
    for (int unsigned m = 0; m < NUM_M; m++)
      if (gnt_d[m]) owner_d = MW'(m);
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_d != gnt_q)
      starve_d = '0;
    else if (others_req && (starve_q < SC_W'(STARVE_MAX)))
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned s = 0; s < NUM_S; s++)
      if (32'(rsp_s_q) == s) rd_mux = s_rdata_i[s*DATA_W +: DATA_W];
  end

  // Slaves answer one cycle after the access, so data is muxed live while valid and held otherwise
  assign m_rdata_o = rsp_v_q ? rd_mux : rdata_q;

  always_comb begin
    m_rvalid_o = '0;
    for (int unsigned m = 0; m < NUM_M; m++)
      m_rvalid_o[m] = rsp_v_q && (32'(rsp_m_q) == m);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= PARK_OH;
      owner_q  <= MW'(PARK_M);
      starve_q <= '0;
      rsp_v_q  <= 1'b0;
      rsp_m_q  <= '0;
      rsp_s_q  <= '0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      rsp_v_q  <= own_rd;
      if (own_rd) begin
        rsp_m_q <= owner_q;
        rsp_s_q <= own_sidx;
      end
      rdata_q  <= m_rdata_o;
    end
  end

`ifdef RIB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q;

  assign to_hit = own_req && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (to_hit || (gnt_d != gnt_q) || !own_req)
      to_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= to_hit;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYC;
  assign to_hit         = 1'b0;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter; read responses are checked against a cycle-tagged scoreboard.
module tb_rib_arbiter;

  localparam int unsigned NM = 3;
  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_req, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_gnt, m_rvalid;
  logic [DW-1:0]    m_rdata;
  logic [NS-1:0]    s_sel;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic             core_hold, err;

  logic [DW-1:0]    slv_q [NS] = '{default: '0};
  logic [DW-1:0]    last_rd;
  int               total = 0;
  int               bad   = 0;
  int               cyc   = 0;

  typedef struct {
    int            due;
    logic [NM-1:0] m;
    logic [DW-1:0] d;
  } rsp_t;
  rsp_t sb[$];

  always #5 clk = ~clk;

  rib_arbiter #(
    .NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .PARK_M(2),
    .CORE_MASK(3'b110), .STARVE_MAX(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rdata_o(m_rdata), .m_rvalid_o(m_rvalid),
    .s_sel_o(s_sel), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata), .core_hold_o(core_hold), .err_o(err)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a ^ 32'hCEAD_BEEB;
  endfunction

  // Synchronous slaves with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < NS; s++)
      if (s_sel[s] && !s_we) slv_q[s] <= pat(s_addr);
  end

  always_comb begin
    for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = slv_q[s];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[m]             = req;
    m_we[m]              = we;
    m_addr[m*AW +: AW]   = a;
    m_wdata[m*DW +: DW]  = d;
  endtask

  task automatic exp_rd(input int m, input logic [DW-1:0] d);
    logic [NM-1:0] oh;
    oh    = '0;
    oh[m] = 1'b1;
    sb.push_back('{due: cyc + 1, m: oh, d: d});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_rd = '0;
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rvalid", m_rvalid, sb[0].m);
      chk("rdata", m_rdata, sb[0].d);
      last_rd = sb[0].d;
      void'(sb.pop_front());
    end else begin
      chk("rvalid_idle", m_rvalid, '0);
      chk("rdata_hold", m_rdata, last_rd);
    end
  end

  initial begin
    int            waited;
    int            errs;
    logic [NM-1:0] gnt_at_err;

    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    settle();
    chk("rst_gnt", m_gnt, 3'b100);
    chk("rst_hold", core_hold, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", m_rdata, '0);

    // Parked M2 reads back-to-back from RAM then UART
    step(); drive(2, 1'b1, 1'b0, 32'h1000_0004, '0); exp_rd(2, 32'hDEAD_BEEF);
    settle();
    chk("rd_sel", s_sel, 4'b0010);
    chk("rd_addr", s_addr, 32'h1000_0004);
    chk("rd_we", s_we, 1'b0);
    chk("rd_hold", core_hold, 1'b0);
    step(); drive(2, 1'b1, 1'b0, 32'h2000_0008, '0); exp_rd(2, pat(32'h2000_0008));
    settle();
    chk("rd2_sel", s_sel, 4'b0100);
    step(); drive(2, 1'b0, 1'b0, '0, '0);
    settle();

    // M1 write while parked on M2
    step(); drive(1, 1'b1, 1'b1, 32'h1000_0010, 32'h0000_55AA);
    settle();
    chk("wr0_hold", core_hold, 1'b1);
    chk("wr0_we", s_we, 1'b0);
    chk("wr0_gnt", m_gnt, 3'b100);
    step(); settle();
    chk("wr1_gnt", m_gnt, 3'b010);
    chk("wr1_we", s_we, 1'b1);
    chk("wr1_wdata", s_wdata, 32'h0000_55AA);
    chk("wr1_sel", s_sel, 4'b0010);
    chk("wr1_hold", core_hold, 1'b0);
    step(); drive(1, 1'b0, 1'b0, '0, '0);
    settle();
    chk("wr2_gnt", m_gnt, 3'b010);
    step(); settle();
    chk("wr3_gnt", m_gnt, 3'b100);

    // M0 and M1 together from park
    step();
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_1111);
    drive(1, 1'b1, 1'b1, 32'h3000_0000, 32'h0000_2222);
    settle();
    chk("pr0_gnt", m_gnt, 3'b100);
    chk("pr0_hold", core_hold, 1'b1);
    step(); settle();
    chk("pr1_gnt", m_gnt, 3'b001);
    chk("pr1_hold", core_hold, 1'b1);
    chk("pr1_sel", s_sel, 4'b0001);
    chk("pr1_wdata", s_wdata, 32'h0000_1111);
    for (int i = 0; i < 2; i++) begin
      step(); settle();
      chk("pr_keep_gnt", m_gnt, 3'b001);
    end
    step(); drive(0, 1'b0, 1'b0, '0, '0);
    settle();
    chk("pr_drop_gnt", m_gnt, 3'b001);
    step(); settle();
    chk("pr_m1_gnt", m_gnt, 3'b010);
    chk("pr_m1_sel", s_sel, 4'b1000);
    chk("pr_m1_hold", core_hold, 1'b0);
    step(); drive(1, 1'b0, 1'b0, '0, '0);
    settle();
    step(); settle();
    chk("pr_park_gnt", m_gnt, 3'b100);

    // Starvation: M0 writes continuously, M2 waits for a read
    step(); drive(0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_3333);
    settle();
    step(); drive(2, 1'b1, 1'b0, 32'h1000_0008, '0);
    settle();
    chk("st_gnt", m_gnt, 3'b001);
    chk("st_hold", core_hold, 1'b1);
    waited = 1;
    while (m_gnt !== 3'b100 && waited < 30) begin
      step(); settle();
      waited++;
    end
    // starve_cnt reaches 8 after 8 waiting edges; the forced switch lands one edge later
    chk("st_wait", waited - 1, 9);
    exp_rd(2, pat(32'h1000_0008));
    chk("st_sel", s_sel, 4'b0010);
    chk("st_hold2", core_hold, 1'b0);
    step(); drive(2, 1'b0, 1'b0, '0, '0);
    settle();
    chk("st_m2_gnt", m_gnt, 3'b100);
    step(); settle();
    chk("st_back_gnt", m_gnt, 3'b001);
    step(); drive(0, 1'b0, 1'b0, '0, '0);
    settle();
    step(); settle();
    chk("st_park_gnt", m_gnt, 3'b100);

    // Reset while M0 owns the bus with a read in flight
    step(); drive(0, 1'b1, 1'b0, 32'h0000_0100, '0);
    settle();
    step(); settle();
    chk("mr_gnt", m_gnt, 3'b001);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_gnt", m_gnt, 3'b100);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); @(negedge clk); @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk("mr_post_gnt", m_gnt, 3'b100);
    chk("mr_post_rdata", m_rdata, '0);

    // Unmapped read
    step(); drive(2, 1'b1, 1'b0, 32'hF000_0000, '0); exp_rd(2, '0);
    settle();
    chk("um_sel", s_sel, 4'b0000);
    step(); drive(2, 1'b0, 1'b0, '0, '0);
    settle();

    // Long ownership by M0: watchdog only when built in
    step(); drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_4444);
    errs       = 0;
    gnt_at_err = '0;
    for (int i = 0; i < 24; i++) begin
      step(); settle();
      if (err === 1'b1) begin
        errs++;
        gnt_at_err = m_gnt;
      end
    end
`ifdef RIB_TIMEOUT_EN
    chk("to_pulses", errs, 1);
    chk("to_gnt", gnt_at_err, 3'b100);
`else
    chk("to_pulses", errs, 0);
    chk("to_gnt_hold", m_gnt, 3'b001);
`endif
    step(); drive(0, 1'b0, 1'b0, '0, '0);
    settle();
    step(); settle();
    chk("end_gnt", m_gnt, 3'b100);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
